// File: rtl/regfile_scoreboard.sv
// Issue-side RAW/WAW hazard scoreboard for the 32-entry integer register file.
// Optional macro SB_WAW_STALL_EN: allow at most one in-flight write per register.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CW    = 2,
    parameter int TW    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [AW-1:0]    issue_rs1,
    input  logic [AW-1:0]    issue_rs2,
    input  logic [AW-1:0]    issue_rd,
    input  logic             issue_wen,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy_mask,
    output logic [TW-1:0]    total_pending,
    output logic             draining,
    output logic             wb_underflow
);

    typedef enum logic {RUN, DRAIN} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q [NREGS];
    logic [CW-1:0] cnt_d [NREGS];
    logic [TW-1:0] total_q, total_d;
    logic          uf_q, uf_d;
    state_t        state_q, state_d;

    logic raw_hz, sat, fire, inc_any, dec_any, uf_hit;

    // Hazards look only at registered counters; a same-cycle writeback is not bypassed.
    assign raw_hz = (issue_rs1 != '0 && cnt_q[issue_rs1] != '0) ||
                    (issue_rs2 != '0 && cnt_q[issue_rs2] != '0);

`ifdef SB_WAW_STALL_EN
    assign sat = issue_wen && issue_rd != '0 && cnt_q[issue_rd] != '0;
`else
    assign sat = issue_wen && issue_rd != '0 && cnt_q[issue_rd] == CNT_MAX;
`endif

    assign issue_ready = (state_q == RUN) && !flush && !raw_hz && !sat && !reset;
    assign fire        = issue_valid && issue_ready;
    assign inc_any     = fire && issue_wen && issue_rd != '0;
    assign dec_any     = wb_valid && wb_rd != '0 && cnt_q[wb_rd] != '0;
    assign uf_hit      = wb_valid && wb_rd != '0 && cnt_q[wb_rd] == '0;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i != 0) begin
                if (inc_any && issue_rd == AW'(i) && !(dec_any && wb_rd == AW'(i)))
                    cnt_d[i] = cnt_q[i] + CW'(1);
                else if (dec_any && wb_rd == AW'(i) && !(inc_any && issue_rd == AW'(i)))
                    cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        total_d = total_q;
        if (inc_any && !dec_any)
            total_d = total_q + TW'(1);
        else if (dec_any && !inc_any)
            total_d = total_q - TW'(1);
        uf_d = uf_q | uf_hit;
    end

    // Flush drains everything already issued; DRAIN exits one cycle after the count hits zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush && (total_q != '0 || total_d != '0))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (total_q == '0)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                cnt_q[i] <= '0;
            total_q <= '0;
            uf_q    <= 1'b0;
            state_q <= RUN;
        end else begin
            for (int i = 0; i < NREGS; i++)
                cnt_q[i] <= cnt_d[i];
            total_q <= total_d;
            uf_q    <= uf_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 1; i < NREGS; i++)
            busy_mask[i] = (cnt_q[i] != '0);
    end

    assign total_pending = total_q;
    assign draining      = (state_q == DRAIN);
    assign wb_underflow  = uf_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard (default build).
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_wen;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic [6:0]  total_pending;
    logic        draining;
    logic        wb_underflow;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    regfile_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_wen     (issue_wen),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .busy_mask     (busy_mask),
        .total_pending (total_pending),
        .draining      (draining),
        .wb_underflow  (wb_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        fl;
        logic        rdy;
        logic [31:0] busy;
        logic [6:0]  tot;
        logic        drn;
        logic        uf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rst, int iv, int rs1, int rs2, int rd, int wen,
                                int wbv, int wbrd, int fl,
                                int rdy, int busy, int tot, int drn, int uf);
        vec_t v;
        v.rst  = 1'(rst);
        v.iv   = 1'(iv);
        v.rs1  = 5'(rs1);
        v.rs2  = 5'(rs2);
        v.rd   = 5'(rd);
        v.wen  = 1'(wen);
        v.wbv  = 1'(wbv);
        v.wbrd = 5'(wbrd);
        v.fl   = 1'(fl);
        v.rdy  = 1'(rdy);
        v.busy = 32'(busy);
        v.tot  = 7'(tot);
        v.drn  = 1'(drn);
        v.uf   = 1'(uf);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset       = v.rst;
        issue_valid = v.iv;
        issue_rs1   = v.rs1;
        issue_rs2   = v.rs2;
        issue_rd    = v.rd;
        issue_wen   = v.wen;
        wb_valid    = v.wbv;
        wb_rd       = v.wbrd;
        flush       = v.fl;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input int row, input vec_t v);
        chk($sformatf("row%0d issue_ready", row),   32'(issue_ready),   32'(v.rdy));
        chk($sformatf("row%0d busy_mask", row),     busy_mask,          v.busy);
        chk($sformatf("row%0d total_pending", row), 32'(total_pending), 32'(v.tot));
        chk($sformatf("row%0d draining", row),      32'(draining),      32'(v.drn));
        chk($sformatf("row%0d wb_underflow", row),  32'(wb_underflow),  32'(v.uf));
    endtask

    initial begin
        //                rst iv rs1 rs2 rd wen wbv wbrd fl | rdy busy    tot drn uf
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,    0, 0, 0)); // 0 post-reset state
        tbl.push_back(mk(0, 1, 0, 0, 5, 1, 0, 0, 0,   1, 32'h0,    0, 0, 0)); // 1 write x5
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 1, 5, 0,   0, 32'h20,   1, 0, 0)); // 2 reader stalls, wb x5
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0,   1, 32'h0,    0, 0, 0)); // 3 reader released
        tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0,   1, 32'h0,    0, 0, 0)); // 4 write x7
        tbl.push_back(mk(0, 1, 0, 0, 7, 1, 1, 7, 0,   1, 32'h80,   1, 0, 0)); // 5 inc+dec same reg
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h80,   1, 0, 0)); // 6 count held at 1
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 0,   1, 32'h80,   1, 0, 0)); // 7 wb x7
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0,   1, 32'h0,    0, 0, 0)); // 8 x0 traffic
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0,   1, 32'h0,    0, 0, 0)); // 9 x0 traffic
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0,   1, 32'h0,    0, 0, 0)); // 10 x3 #1
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0,   1, 32'h8,    1, 0, 0)); // 11 x3 #2
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0,   1, 32'h8,    2, 0, 0)); // 12 x3 #3
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0,   0, 32'h8,    3, 0, 0)); // 13 x3 #4 saturated
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 1, 3, 0,   0, 32'h8,    3, 0, 0)); // 14 still saturated, wb
        tbl.push_back(mk(0, 0, 0, 0, 3, 1, 1, 3, 0,   1, 32'h8,    2, 0, 0)); // 15 room again, wb
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0,   1, 32'h8,    1, 0, 0)); // 16 last wb x3
        tbl.push_back(mk(0, 1, 0, 0, 10, 1, 0, 0, 0,  1, 32'h0,    0, 0, 0)); // 17 write x10
        tbl.push_back(mk(0, 1, 0, 0, 11, 1, 0, 0, 0,  1, 32'h400,  1, 0, 0)); // 18 write x11
        tbl.push_back(mk(0, 1, 0, 0, 12, 1, 0, 0, 1,  0, 32'hC00,  2, 0, 0)); // 19 flush
        tbl.push_back(mk(0, 1, 0, 0, 12, 1, 1, 10, 0, 0, 32'hC00,  2, 1, 0)); // 20 draining, wb x10
        tbl.push_back(mk(0, 1, 0, 0, 12, 1, 1, 11, 1, 0, 32'h800,  1, 1, 0)); // 21 flush ignored, wb x11
        tbl.push_back(mk(0, 1, 0, 0, 12, 1, 0, 0, 0,  0, 32'h0,    0, 1, 0)); // 22 pending hit zero
        tbl.push_back(mk(0, 1, 0, 0, 12, 1, 0, 0, 0,  1, 32'h0,    0, 0, 0)); // 23 back to RUN
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12, 0,  1, 32'h1000, 1, 0, 0)); // 24 wb x12
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 0,   1, 32'h0,    0, 0, 0)); // 25 stray wb x9
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,    0, 0, 1)); // 26 underflow sticky
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,    0, 0, 1)); // 27 still sticky
        tbl.push_back(mk(1, 1, 0, 0, 4, 1, 0, 0, 0,   0, 32'h0,    0, 0, 1)); // 28 reset blocks issue
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,    0, 0, 0)); // 29 cleared by reset

        // Initial reset so the first table row sees defined state.
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            drive(tbl[r]);
            #1;
            check_all(r, tbl[r]);
        end

        // Reset while draining returns to RUN with nothing pending.
        @(negedge clk);
        drive(mk(0, 1, 0, 0, 20, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("h1 issue_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        drive(mk(0, 1, 0, 0, 21, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        #1 chk("h2 flush issue_ready", 32'(issue_ready), 32'd0);
        chk("h2 total_pending", 32'(total_pending), 32'd1);
        @(negedge clk);
        drive(mk(0, 1, 0, 0, 21, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("h3 draining", 32'(draining), 32'd1);
        chk("h3 issue_ready", 32'(issue_ready), 32'd0);
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("h4 draining", 32'(draining), 32'd1);
        chk("h4 issue_ready", 32'(issue_ready), 32'd0);
        @(negedge clk);
        drive(mk(0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("h5 draining", 32'(draining), 32'd0);
        chk("h5 busy_mask", busy_mask, 32'h0);
        chk("h5 total_pending", 32'(total_pending), 32'd0);
        chk("h5 issue_ready", 32'(issue_ready), 32'd1);

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
